sipo_rx_frame_buffer: RTL and testbench

- Receive-side datapath stage directly downstream of the SIPO controller.
- On every controller `shift` strobe it samples the serial line into a frame shift register.
- At frame end it checks start, parity and stop bits.
- It pushes the de-framed data word plus error flags into a small FIFO. Consumers drain the FIFO through a valid/ready handshake.

---
 rtl/sipo_rx_frame_buffer.sv | 92 +++++++++
 tb/tb_sipo_rx_frame_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx_frame_buffer.sv
// sipo_rx_frame_buffer: samples serial frame bits on shift strobes, checks start/parity/stop
// and buffers {data, parity_err, frame_err} in a small FIFO drained by valid/ready.
module sipo_rx_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  baud_clk,
  input  logic                  rst,
  input  logic                  data_tx,
  input  logic                  shift,
  input  logic                  frame_abort,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic [3:0]            bit_idx,
  output logic [LW-1:0]         fifo_level
);
  localparam int N = 2 + DATA_WIDTH + PARITY_EN;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [3:0] LAST = 4'(N - 1);

  logic [N-1:0]  sr_q, sr_d;
  logic [3:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovr_q, ovr_d;
  logic          par_err, frm_err, full, push, pop;

  always_comb begin
    idx_d = idx_q;
    sr_d = sr_q;
    done_d = 1'b0;
    if (frame_abort) idx_d = '0;
    else if (shift) begin
      sr_d[idx_q] = data_tx;
      idx_d = (idx_q == LAST) ? 4'd0 : idx_q + 4'd1;
      done_d = (idx_q == LAST);
    end
  end

  // Frame is checked one cycle after the stop sample, while sr_q still holds it intact.
  assign par_err = (PARITY_EN != 0) && ((^sr_q[DATA_WIDTH:1]) ^ sr_q[DATA_WIDTH+1] ^ (PARITY_ODD != 0));
  assign frm_err = sr_q[0] | ~sr_q[N-1];

  assign full = (lvl_q == LW'(FIFO_DEPTH));
  assign pop  = (lvl_q != '0) && rx_ready;
  assign push = done_q && (!full || pop);

  always_comb begin
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    ovr_d = done_q && full && !pop;
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sr_q <= sr_d;
      idx_q <= idx_d;
      done_q <= done_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      ovr_q <= ovr_d;
      if (push) mem_q[wr_q] <= {sr_q[DATA_WIDTH:1], par_err, frm_err};
    end
  end

  assign {rx_data, rx_parity_err, rx_frame_err} = mem_q[rd_q];
  assign rx_valid = (lvl_q != '0);
  assign overrun = ovr_q;
  assign bit_idx = idx_q;
  assign fifo_level = lvl_q;
endmodule

// File: tb/tb_sipo_rx_frame_buffer.sv
// tb_sipo_rx_frame_buffer: directed frames with hand-computed expectations for the rx frame buffer.
module tb_sipo_rx_frame_buffer;
  logic       baud_clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_tx = 1'b1;
  logic       shift = 1'b0;
  logic       frame_abort = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, overrun;
  logic [3:0] bit_idx;
  logic [2:0] fifo_level;
  int nvec = 0;
  int nerr = 0;

  sipo_rx_frame_buffer dut (
    .baud_clk(baud_clk), .rst(rst), .data_tx(data_tx), .shift(shift),
    .frame_abort(frame_abort), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .bit_idx(bit_idx), .fifo_level(fifo_level)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge baud_clk);
  endtask

  task automatic send_bit(input logic b);
    shift = 1'b1;
    data_tx = b;
    @(negedge baud_clk);
    shift = 1'b0;
    data_tx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    logic [10:0] f;
    f = {stop, (^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
  endtask

  initial begin
    cyc(2);
    chk("rst_valid", rx_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    cyc(1);

    // good frame, consumer ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("good_valid_early", rx_valid, 0);
    cyc(1);
    chk("good_valid", rx_valid, 1);
    chk("good_data", rx_data, 8'hA5);
    chk("good_perr", rx_parity_err, 0);
    chk("good_ferr", rx_frame_err, 0);
    cyc(1);
    chk("good_popped", rx_valid, 0);
    rx_ready = 1'b0;

    // error frames
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    cyc(2);
    chk("err_level", fifo_level, 2);
    chk("perr_data", rx_data, 8'h3C);
    chk("perr_flag", rx_parity_err, 1);
    chk("perr_ferr", rx_frame_err, 0);
    cyc(1);
    chk("hold_data", rx_data, 8'h3C);
    chk("hold_perr", rx_parity_err, 1);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_perr", rx_parity_err, 0);
    chk("ferr_flag", rx_frame_err, 1);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    chk("err_drained", fifo_level, 0);

    // overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    chk("ovr_early", overrun, 0);
    cyc(1);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_level", fifo_level, 4);
    cyc(1);
    chk("ovr_clear", overrun, 0);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_drain", rx_data, i);
      cyc(1);
    end
    rx_ready = 1'b0;
    chk("ovr_empty", fifo_level, 0);
    chk("ovr_valid", rx_valid, 0);

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
    cyc(2);
    chk("full_level", fifo_level, 4);
    send_frame(8'h15, 1'b0, 1'b1);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    chk("full_no_ovr", overrun, 0);
    chk("full_level_kept", fifo_level, 4);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain", rx_data, 8'h12 + 8'(i));
      cyc(1);
    end
    rx_ready = 1'b0;
    chk("full_empty", fifo_level, 0);

    // abort mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("abort_idx5", bit_idx, 5);
    frame_abort = 1'b1;
    cyc(1);
    frame_abort = 1'b0;
    chk("abort_idx0", bit_idx, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    cyc(2);
    chk("abort_level", fifo_level, 1);
    chk("abort_data", rx_data, 8'h5A);
    chk("abort_ferr", rx_frame_err, 0);
    chk("abort_perr", rx_parity_err, 0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    shift = 1'b1;
    frame_abort = 1'b1;
    cyc(1);
    shift = 1'b0;
    frame_abort = 1'b0;
    chk("abort_shift_idx", bit_idx, 0);
    cyc(3);
    chk("abort_no_push", fifo_level, 0);

    // reset mid-frame with two buffered entries
    send_frame(8'h77, 1'b0, 1'b1);
    send_frame(8'h88, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    chk("pre_rst_level", fifo_level, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_idx", bit_idx, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    send_frame(8'hC3, 1'b0, 1'b1);
    cyc(1);
    chk("post_rst_valid", rx_valid, 1);
    chk("post_rst_data", rx_data, 8'hC3);
    chk("post_rst_level", fifo_level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
